store_queue: RTL and testbench

Circular store queue that sits behind the memory functional unit. It allocates one entry per store at dispatch and captures the store's address and data when the store executes. It answers the load-side forwarding lookup in the same cycle. It holds stores until the ROB retires them, then drains committed stores to the dcache in program order.

---
 rtl/store_queue_pkg.sv | 33 +++
 rtl/store_queue_if.sv | 36 +++
 rtl/store_queue_forward_search.sv | 48 ++++
 rtl/store_queue.sv | 94 +++++++++
 tb/tb_store_queue.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/store_queue_pkg.sv
// Shared types for the store queue: index/address/data types, store widths,
// per-entry state and the execute-write packet from the memory FU.
package store_queue_pkg;
  localparam int SQ_DEPTH = 8;
  localparam int IDX_W    = $clog2(SQ_DEPTH);

  typedef logic [IDX_W-1:0] STOREQ_IDX;
  typedef logic [31:0]      ADDR;
  typedef logic [31:0]      DATA;

  typedef enum logic [1:0] {STORE_BYTE, STORE_HALF, STORE_WORD, STORE_DOUBLE} MEM_FUNC;
  typedef enum logic [1:0] {FREE, ALLOC, READY, COMMITTED} SQ_STATE;

  typedef struct packed {
    logic      valid;
    ADDR       addr;
    DATA       data;
    STOREQ_IDX store_queue_idx;
  } EXECUTE_STOREQ_ENTRY;

  typedef struct packed {
    SQ_STATE state;
    MEM_FUNC func;
    ADDR     addr;
    DATA     data;
  } sq_entry_t;

  // Doubles cover an aligned 8-byte span, everything else an aligned word.
  function automatic logic addr_match(MEM_FUNC f, ADDR store_addr, ADDR load_addr);
    if (f == STORE_DOUBLE) return (store_addr >> 3) == (load_addr >> 3);
    return (store_addr >> 2) == (load_addr >> 2);
  endfunction
endpackage

// File: rtl/store_queue_if.sv
// Dispatch / execute / lookup / retire / dcache-drain signals of the store queue.
interface store_queue_if import store_queue_pkg::*; ();
  logic                alloc_valid;
  MEM_FUNC             alloc_func;
  logic                alloc_ready;
  STOREQ_IDX           alloc_idx;
  EXECUTE_STOREQ_ENTRY exec_entry;
  logic                lookup_valid;
  ADDR                 lookup_addr;
  STOREQ_IDX           lookup_sq_tail;
  logic                forward_valid;
  DATA                 forward_data;
  logic                forward_stall;
  logic                retire_valid;
  logic                flush;
  logic                dcache_store_valid;
  ADDR                 dcache_store_addr;
  DATA                 dcache_store_data;
  MEM_FUNC             dcache_store_func;
  logic                dcache_store_accept;
  logic                sq_empty;

  modport master (
    output alloc_valid, alloc_func, exec_entry, lookup_valid, lookup_addr, lookup_sq_tail,
           retire_valid, flush, dcache_store_accept,
    input  alloc_ready, alloc_idx, forward_valid, forward_data, forward_stall,
           dcache_store_valid, dcache_store_addr, dcache_store_data, dcache_store_func, sq_empty
  );

  modport slave (
    input  alloc_valid, alloc_func, exec_entry, lookup_valid, lookup_addr, lookup_sq_tail,
           retire_valid, flush, dcache_store_accept,
    output alloc_ready, alloc_idx, forward_valid, forward_data, forward_stall,
           dcache_store_valid, dcache_store_addr, dcache_store_data, dcache_store_func, sq_empty
  );
endinterface

// File: rtl/store_queue_forward_search.sv
// Load-side forwarding search: youngest older store matching the load address,
// plus the stall decision. Only built when SQ_FORWARD_EN is defined.
`ifdef SQ_FORWARD_EN
module sq_forward_search import store_queue_pkg::*; (
  input  sq_entry_t [SQ_DEPTH-1:0] entries,
  input  STOREQ_IDX                head_idx,
  input  logic                     lookup_valid,
  input  ADDR                      lookup_addr,
  input  STOREQ_IDX                lookup_sq_tail,
  output logic                     forward_valid,
  output DATA                      forward_data,
  output logic                     forward_stall
);
  STOREQ_IDX span;
  STOREQ_IDX idx;
  logic      unknown, hit;
  MEM_FUNC   hit_func;
  DATA       hit_data;

  assign span = lookup_sq_tail - head_idx;

  // Walk oldest to youngest so the last hit left standing is the youngest.
  always_comb begin
    unknown  = 1'b0;
    hit      = 1'b0;
    hit_func = STORE_BYTE;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < SQ_DEPTH; i++) begin
      idx = head_idx + STOREQ_IDX'(i);
      if (STOREQ_IDX'(i) < span) begin
        if (entries[idx].state == ALLOC) begin
          unknown = 1'b1;
        end else if (entries[idx].state != FREE &&
                     addr_match(entries[idx].func, entries[idx].addr, lookup_addr)) begin
          hit      = 1'b1;
          hit_func = entries[idx].func;
          hit_data = entries[idx].data;
        end
      end
    end
  end

  assign forward_stall = lookup_valid && (unknown || (hit && hit_func != STORE_WORD));
  assign forward_valid = lookup_valid && !unknown && hit && hit_func == STORE_WORD;
  assign forward_data  = forward_valid ? hit_data : '0;
endmodule
`endif

// File: rtl/store_queue.sv
// Circular store queue: allocate at dispatch, capture at execute, commit on retire,
// drain to dcache in order. SQ_FORWARD_EN enables store-to-load forwarding.
module store_queue import store_queue_pkg::*; (
  input logic           clock,
  input logic           reset,
  store_queue_if.slave  sq
);
  typedef logic [IDX_W:0] ptr_t;

  ptr_t      head, commit_ptr, tail;
  ptr_t      head_n, commit_n, tail_n, count;
  STOREQ_IDX head_idx, commit_idx, tail_idx, exec_idx;
  sq_entry_t [SQ_DEPTH-1:0] entries, entries_n;
  logic      full, alloc_fire, drain_fire;

  assign head_idx   = head[IDX_W-1:0];
  assign commit_idx = commit_ptr[IDX_W-1:0];
  assign tail_idx   = tail[IDX_W-1:0];
  assign exec_idx   = sq.exec_entry.store_queue_idx;
  assign count      = tail - head;
  assign full       = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);

  assign sq.alloc_ready = !full;
  assign sq.alloc_idx   = tail_idx;
  assign sq.sq_empty    = (count == '0);

  assign alloc_fire = sq.alloc_valid && !full && !sq.flush;

  assign sq.dcache_store_valid = (entries[head_idx].state == COMMITTED);
  assign sq.dcache_store_addr  = sq.dcache_store_valid ? entries[head_idx].addr : '0;
  assign sq.dcache_store_data  = sq.dcache_store_valid ? entries[head_idx].data : '0;
  assign sq.dcache_store_func  = sq.dcache_store_valid ? entries[head_idx].func : STORE_BYTE;
  assign drain_fire = sq.dcache_store_valid && sq.dcache_store_accept;

  // Updates are ordered so a same-cycle retire survives the flush and a
  // same-cycle exec write to a flushed entry is discarded.
  always_comb begin
    entries_n = entries;
    commit_n  = commit_ptr + ptr_t'(sq.retire_valid);
    head_n    = head + ptr_t'(drain_fire);
    tail_n    = sq.flush ? commit_n : tail + ptr_t'(alloc_fire);
    if (sq.exec_entry.valid && entries[exec_idx].state == ALLOC) begin
      entries_n[exec_idx].state = READY;
      entries_n[exec_idx].addr  = sq.exec_entry.addr;
      entries_n[exec_idx].data  = sq.exec_entry.data;
    end
    if (sq.retire_valid) entries_n[commit_idx].state = COMMITTED;
    if (sq.flush) begin
      for (int i = 0; i < SQ_DEPTH; i++)
        if (entries_n[i].state inside {ALLOC, READY}) entries_n[i] = '0;
    end
    if (drain_fire) entries_n[head_idx] = '0;
    if (alloc_fire) begin
      entries_n[tail_idx]       = '0;
      entries_n[tail_idx].state = ALLOC;
      entries_n[tail_idx].func  = sq.alloc_func;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head       <= '0;
      commit_ptr <= '0;
      tail       <= '0;
      entries    <= '0;
    end else begin
      head       <= head_n;
      commit_ptr <= commit_n;
      tail       <= tail_n;
      entries    <= entries_n;
    end
  end

  a_retire_ready: assert property (@(posedge clock) disable iff (reset)
    sq.retire_valid |-> entries[commit_idx].state == READY);

`ifdef SQ_FORWARD_EN
  sq_forward_search u_search (
    .entries        (entries),
    .head_idx       (head_idx),
    .lookup_valid   (sq.lookup_valid),
    .lookup_addr    (sq.lookup_addr),
    .lookup_sq_tail (sq.lookup_sq_tail),
    .forward_valid  (sq.forward_valid),
    .forward_data   (sq.forward_data),
    .forward_stall  (sq.forward_stall)
  );
`else
  // Without forwarding, a load simply waits for every older store to drain.
  assign sq.forward_valid = 1'b0;
  assign sq.forward_data  = '0;
  assign sq.forward_stall = sq.lookup_valid && (sq.lookup_sq_tail != head_idx);
`endif
endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: drain scoreboard plus forwarding lookups,
// expectations follow whether SQ_FORWARD_EN is defined.
module tb_store_queue;
  import store_queue_pkg::*;

`ifdef SQ_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {ADDR addr; DATA data; MEM_FUNC func;} exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];

  store_queue_if sqi();
  store_queue dut (.clock(clock), .reset(reset), .sq(sqi));

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clock); #1;
    sqi.alloc_valid = 1'b0; sqi.exec_entry = '0; sqi.retire_valid = 1'b0;
    sqi.flush = 1'b0; sqi.dcache_store_accept = 1'b0; sqi.lookup_valid = 1'b0;
  endtask

  task automatic do_alloc(MEM_FUNC f);
    sqi.alloc_valid = 1'b1; sqi.alloc_func = f;
  endtask

  task automatic do_exec(STOREQ_IDX idx, ADDR a, DATA d, MEM_FUNC f);
    sqi.exec_entry = '{valid: 1'b1, addr: a, data: d, store_queue_idx: idx};
    sb.push_back('{a, d, f});
  endtask

  task automatic lookup(string tag, ADDR a, STOREQ_IDX t, logic efv, DATA efd, logic efs);
    sqi.lookup_valid = 1'b1; sqi.lookup_addr = a; sqi.lookup_sq_tail = t;
    #1;
    chk({tag, ".fv"}, 64'(sqi.forward_valid), 64'(efv));
    chk({tag, ".fd"}, 64'(sqi.forward_data),  64'(efd));
    chk({tag, ".fs"}, 64'(sqi.forward_stall), 64'(efs));
    sqi.lookup_valid = 1'b0;
  endtask

  // Compare the presented head store with the oldest expected store and accept it.
  task automatic drain_check(string tag);
    exp_t e;
    chk({tag, ".valid"}, 64'(sqi.dcache_store_valid), 64'(1));
    chk({tag, ".sb"}, 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".addr"}, 64'(sqi.dcache_store_addr), 64'(e.addr));
      chk({tag, ".data"}, 64'(sqi.dcache_store_data), 64'(e.data));
      chk({tag, ".func"}, 64'(sqi.dcache_store_func), 64'(e.func));
    end
    sqi.dcache_store_accept = 1'b1;
  endtask

  initial begin
    sqi.alloc_valid = 0; sqi.alloc_func = STORE_WORD; sqi.exec_entry = '0;
    sqi.lookup_valid = 0; sqi.lookup_addr = '0; sqi.lookup_sq_tail = '0;
    sqi.retire_valid = 0; sqi.flush = 0; sqi.dcache_store_accept = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("rst.alloc_ready", 64'(sqi.alloc_ready), 64'(1));
    chk("rst.alloc_idx",   64'(sqi.alloc_idx), 64'(0));
    chk("rst.empty",       64'(sqi.sq_empty), 64'(1));
    chk("rst.dc_valid",    64'(sqi.dcache_store_valid), 64'(0));
    chk("rst.dc_addr",     64'(sqi.dcache_store_addr), 64'(0));
    chk("rst.dc_data",     64'(sqi.dcache_store_data), 64'(0));
    chk("rst.dc_func",     64'(sqi.dcache_store_func), 64'(0));
    lookup("rst.lookup", 32'h1000, 3'd0, 1'b0, 32'h0, 1'b0);

    // Fill and drain
    for (int i = 0; i < 8; i++) begin
      chk("fill.idx", 64'(sqi.alloc_idx), 64'(i));
      do_alloc(STORE_WORD); cycle();
    end
    chk("full.ready", 64'(sqi.alloc_ready), 64'(0));
    chk("full.idx",   64'(sqi.alloc_idx), 64'(0));
    chk("full.empty", 64'(sqi.sq_empty), 64'(0));
    do_alloc(STORE_WORD); cycle();
    chk("ovf.idx",   64'(sqi.alloc_idx), 64'(0));
    chk("ovf.ready", 64'(sqi.alloc_ready), 64'(0));
    for (int i = 0; i < 8; i++) begin
      do_exec(STOREQ_IDX'(i), ADDR'(32'h100 + 4 * i), DATA'(32'hA0 + i), STORE_WORD); cycle();
    end
    for (int i = 0; i < 8; i++) begin
      sqi.retire_valid = 1'b1; cycle();
    end
    for (int i = 0; i < 8; i++) begin
      drain_check("fill.drain");
      if (i == 0) do_alloc(STORE_WORD);
      cycle();
      if (i == 0) begin
        chk("drainfull.idx",   64'(sqi.alloc_idx), 64'(0));
        chk("drainfull.ready", 64'(sqi.alloc_ready), 64'(1));
      end
    end
    chk("fill.empty", 64'(sqi.sq_empty), 64'(1));

    // Word forwarding and stall cases; head = tail = index 0 after wrap
    chk("wrap0.idx", 64'(sqi.alloc_idx), 64'(0));
    do_alloc(STORE_WORD); cycle();
    lookup("alloc_stall", 32'h1002, 3'd1, 1'b0, 32'h0, 1'b1);
    do_exec(3'd0, 32'h1000, 32'hDEADBEEF, STORE_WORD);
    lookup("exec_same", 32'h1002, 3'd1, 1'b0, 32'h0, 1'b1);
    cycle();
    lookup("fwd_word", 32'h1002, 3'd1, FWD, FWD ? 32'hDEADBEEF : 32'h0, !FWD);
    lookup("no_older", 32'h1002, 3'd0, 1'b0, 32'h0, 1'b0);
    do_alloc(STORE_BYTE); cycle();
    do_exec(3'd1, 32'h1001, 32'h55, STORE_BYTE); cycle();
    lookup("sb_stall", 32'h1000, 3'd2, 1'b0, 32'h0, 1'b1);
    lookup("no_match", 32'h3000, 3'd2, 1'b0, 32'h0, !FWD);
    sqi.retire_valid = 1'b1; cycle();
    sqi.retire_valid = 1'b1; cycle();
    drain_check("fwd.drain0"); cycle();
    drain_check("fwd.drain1"); cycle();

    // Youngest older store wins; doubles compare on 8-byte granules
    do_alloc(STORE_WORD); cycle();
    do_alloc(STORE_WORD); cycle();
    do_alloc(STORE_DOUBLE); cycle();
    do_exec(3'd2, 32'h2000, 32'h1, STORE_WORD); cycle();
    do_exec(3'd3, 32'h2000, 32'h2, STORE_WORD); cycle();
    do_exec(3'd4, 32'h2004, 32'h77, STORE_DOUBLE); cycle();
    lookup("youngest",   32'h2000, 3'd4, FWD, FWD ? 32'h2 : 32'h0, !FWD);
    lookup("older_only", 32'h2000, 3'd3, FWD, FWD ? 32'h1 : 32'h0, !FWD);
    lookup("dbl_stall",  32'h2000, 3'd5, 1'b0, 32'h0, 1'b1);
    lookup("dbl_miss",   32'h2008, 3'd5, 1'b0, 32'h0, !FWD);
    for (int i = 0; i < 3; i++) begin
      sqi.retire_valid = 1'b1; cycle();
    end
    for (int i = 0; i < 3; i++) begin
      drain_check("yw.drain"); cycle();
    end

    // Reset mid-operation discards a committed but undrained store
    do_alloc(STORE_WORD); cycle();
    do_exec(3'd5, 32'h5000, 32'h50, STORE_WORD); cycle();
    sqi.retire_valid = 1'b1; cycle();
    chk("mid.dc_valid_pre", 64'(sqi.dcache_store_valid), 64'(1));
    reset = 1'b1; #1;
    chk("mid.dc_valid", 64'(sqi.dcache_store_valid), 64'(0));
    chk("mid.empty",    64'(sqi.sq_empty), 64'(1));
    chk("mid.idx",      64'(sqi.alloc_idx), 64'(0));
    sb.delete();
    cycle();
    reset = 1'b0;

    // Flush with same-cycle retire, alloc and exec to a flushed index
    for (int i = 0; i < 3; i++) begin
      do_alloc(STORE_WORD); cycle();
    end
    do_exec(3'd0, 32'h4000, 32'h40, STORE_WORD); cycle();
    sqi.retire_valid = 1'b1; sqi.flush = 1'b1; do_alloc(STORE_WORD);
    sqi.exec_entry = '{valid: 1'b1, addr: 32'h4100, data: 32'h41, store_queue_idx: 3'd1};
    cycle();
    chk("flush.tail",  64'(sqi.alloc_idx), 64'(1));
    chk("flush.ready", 64'(sqi.alloc_ready), 64'(1));
    chk("flush.empty", 64'(sqi.sq_empty), 64'(0));
    drain_check("flush.drain"); cycle();
    chk("flush.empty2", 64'(sqi.sq_empty), 64'(1));
    chk("flush.tail2",  64'(sqi.alloc_idx), 64'(1));

    // Wrap: one store per cycle through alloc/exec/retire/drain starting at index 1
    for (int k = 0; k < 23; k++) begin
      if (k < 20) begin
        chk("wrap.ready", 64'(sqi.alloc_ready), 64'(1));
        chk("wrap.idx",   64'(sqi.alloc_idx), 64'((1 + k) % 8));
        do_alloc(STORE_WORD);
      end
      if (k >= 1 && k <= 20)
        do_exec(STOREQ_IDX'(k), ADDR'(32'h8000 + 16 * (k - 1)), DATA'(32'h1000_0000 + k - 1), STORE_WORD);
      if (k >= 2 && k <= 21) begin
        sqi.retire_valid = 1'b1;
        lookup("wrap.fwd", ADDR'(32'h8000 + 16 * (k - 2)), STOREQ_IDX'(k), FWD,
               FWD ? DATA'(32'h1000_0000 + k - 2) : 32'h0, !FWD);
      end
      if (k >= 3) drain_check("wrap.drain");
      cycle();
    end
    chk("wrap.empty", 64'(sqi.sq_empty), 64'(1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
